arb_ram: RTL and testbench
==========================

Name: arb_ram

Overview:
- Parametrised, multi-channel successor to the single-port on-chip RAM.
- NUM_CH requestors (e.g. instruction fetch and load/store) share one synchronous word-organised RAM.
- Access is through per-channel valid/ready handshakes with round-robin arbitration, byte-enabled writes and a configurable read latency.
- Read data returns on a shared bus, tagged by a one-hot per-channel rdata_valid.

Parameters:
- DATA_W, 32, data width in bits (multiple of 8).
- ADDR_W, 32, byte-address width per channel.
- DEPTH, 1024, number of DATA_W words (power of two).
- NUM_CH, 2, number of requesting channels (1..8).
- RD_LAT, 1, cycles from read acceptance edge to rdata_valid (1..4).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  NUM_CH  per-channel request valid.
- ready_out  out  NUM_CH  per-channel grant; at most one bit set.
- write_en_in  in  NUM_CH  per-channel write (1) / read (0).
- addr_in  in  NUM_CH*ADDR_W  byte addresses, channel i at [i*ADDR_W +: ADDR_W].
- write_data_in  in  NUM_CH*DATA_W  write data, channel i at [i*DATA_W +: DATA_W].
- byte_en_in  in  NUM_CH*DATA_W/8  write byte enables, channel i at [i*DATA_W/8 +: DATA_W/8].
- rdata_valid_out  out  NUM_CH  one-cycle read-return strobe, one-hot.
- rdata_out  out  DATA_W  shared read data.
- err_out  out  NUM_CH  error strobe (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge):
  - rdata_valid_out=0, rdata_out=0, err_out=0.
  - Read pipeline flushed; in-flight reads are dropped and never return.
  - Round-robin pointer=0, so channel 0 has highest priority.
  - ready_out forced 0 while rst=1.
  - RAM contents are not cleared.
- Arbitration:
  - ready_out is combinational from valid_in and the pointer.
  - Grant goes to the first valid channel searching from pointer, pointer+1, … modulo NUM_CH.
  - No valid channel -> ready_out=0.
  - A transfer occurs on an edge where valid_in[i]&&ready_out[i].
  - After a transfer on channel g, pointer = (g+1) mod NUM_CH; otherwise the pointer holds.
  - Requesters hold all request fields stable while valid && !ready. Valid is not withdrawn before acceptance.
  - Throughput is one access per cycle. The arbiter is fair: each waiting channel is granted within NUM_CH transfers.
- Addressing:
  - word index = addr[$clog2(DATA_W/8) +: $clog2(DEPTH)].
  - Low byte-offset bits are ignored.
  - Without the feature, upper bits are ignored, so addresses wrap modulo DEPTH words.
- Write:
  - At the acceptance edge, byte k is updated iff byte_en[k]=1.
  - byte_en=0 is accepted with no change.
  - Writes produce no rdata_valid.
- Read:
  - Full word is read; byte_en is ignored.
  - rdata_valid_out[ch] pulses exactly RD_LAT cycles after the acceptance edge, with rdata_out valid that cycle.
  - Back-to-back reads from any mix of channels return in acceptance order, one per cycle.
  - rdata_out holds its last value when no strobe is active.
- Ordering:
  - A read accepted on the cycle after a write to the same word returns the new data.
  - Only one access occurs per cycle, so same-cycle read/write collisions cannot happen.
- Reset mid-operation:
  - Reset asserted while reads are in flight suppresses their strobes.
  - Reset also cancels the current cycle's acceptance (ready=0).

Optional Feature:
- Macro: ARB_RAM_ADDR_CHECK_EN.
- Defined: a request is an error if it is
  - out of range: addr >> $clog2(DATA_W/8) >= DEPTH, or
  - a misaligned write: nonzero byte-offset bits with any byte_en set.
- An error request is still accepted but does not touch the RAM.
- Error read: returns rdata_out=0 with rdata_valid_out[ch] and err_out[ch] both pulsing RD_LAT cycles after acceptance.
- Error write: pulses err_out[ch] alone RD_LAT cycles after acceptance.
- Undefined: err_out tied to 0, addresses wrap as above, no checks.

Test Plan:
- Single channel, NUM_CH=2, RD_LAT=1: write 0xffff0000 to addr 0x8 with byte_en=1111, then read 0x8 -> rdata_valid_out=01 one cycle after read acceptance, rdata_out=0xffff0000.
- Partial write: preload word 0x10 with 0x11223344, write 0xaabbccdd with byte_en=0101, read 0x10 -> 0x11bb33dd.
- Contention: both channels hold reads continuously to 0x0 and 0x4 (preloaded 0xA, 0xB) -> grants alternate 01,10,01,…; strobes alternate with data 0xA,0xB,…; no channel starved.
- RD_LAT=3: three back-to-back reads accepted on cycles t, t+1, t+2 -> strobes on t+3, t+4, t+5, in order, with the correct data.
- Reset mid-read: accept read at cycle t, assert rst at t+1 with RD_LAT=3 -> no rdata_valid ever; ready_out=0 during reset; pointer back to 0; previously written data still readable after reset.
- Address checks: with ARB_RAM_ADDR_CHECK_EN and DEPTH=1024, read addr 0x1000 -> err_out and rdata_valid pulse, rdata_out=0. Without the macro, the same read returns word 0's contents.

Source files
------------

// File: rtl/arb_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : arb_ram                                                         |
// | Purpose  : NUM_CH-port round-robin arbitrated, byte-enabled word RAM with  |
// |            a fixed-latency, in-order read return on a shared data bus.     |
// |            Optional address checking under `ARB_RAM_ADDR_CHECK_EN`.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module arb_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int NUM_CH = 2,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          valid_in,
    output logic [NUM_CH-1:0]          ready_out,
    input  logic [NUM_CH-1:0]          write_en_in,
    input  logic [NUM_CH*ADDR_W-1:0]   addr_in,
    input  logic [NUM_CH*DATA_W-1:0]   write_data_in,
    input  logic [NUM_CH*DATA_W/8-1:0] byte_en_in,
    output logic [NUM_CH-1:0]          rdata_valid_out,
    output logic [DATA_W-1:0]          rdata_out,
    output logic [NUM_CH-1:0]          err_out
);

    localparam int c_BE_W  = DATA_W / 8;
    localparam int c_OFF_W = $clog2(c_BE_W);
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_cand;
    logic [c_PTR_W-1:0] w_grant_idx;
    logic [c_PTR_W-1:0] w_ptr_nxt;
    logic               w_grant_found;
    logic [NUM_CH-1:0]  w_grant;
    logic               w_xfer;

    always_comb begin
        w_cand        = '0;
        w_grant_idx   = '0;
        w_grant_found = 1'b0;
        w_grant       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_cand = c_PTR_W'((int'(r_ptr) + k) % NUM_CH);
            if (!w_grant_found && valid_in[w_cand]) begin
                w_grant_found    = 1'b1;
                w_grant_idx      = w_cand;
                w_grant[w_cand]  = 1'b1;
            end
        end
    end

    assign ready_out = rst ? '0 : w_grant;
    assign w_xfer    = |ready_out;
    assign w_ptr_nxt = c_PTR_W'((int'(w_grant_idx) + 1) % NUM_CH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Granted request fields
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [c_BE_W-1:0]  w_sel_be;
    logic               w_sel_we;
    logic [c_IDX_W-1:0] w_word_idx;
    logic               w_err;
    logic               w_unused;

    assign w_sel_addr  = addr_in[w_grant_idx*ADDR_W +: ADDR_W];
    assign w_sel_wdata = write_data_in[w_grant_idx*DATA_W +: DATA_W];
    assign w_sel_be    = byte_en_in[w_grant_idx*c_BE_W +: c_BE_W];
    assign w_sel_we    = write_en_in[w_grant_idx];
    assign w_word_idx  = w_sel_addr[c_OFF_W +: c_IDX_W];

    // Byte-offset and (unchecked) upper address bits do not select a word.
    assign w_unused = ^w_sel_addr;

`ifdef ARB_RAM_ADDR_CHECK_EN
    logic w_oor;
    logic w_misalign;

    generate
        if (ADDR_W > c_OFF_W + c_IDX_W) begin : g_oor
            assign w_oor = |w_sel_addr[ADDR_W-1:c_OFF_W+c_IDX_W];
        end else begin : g_oor_none
            assign w_oor = 1'b0;
        end

        if (c_OFF_W > 0) begin : g_off
            assign w_misalign = |w_sel_addr[(c_OFF_W > 0 ? c_OFF_W-1 : 0):0];
        end else begin : g_off_none
            assign w_misalign = 1'b0;
        end
    endgenerate

    assign w_err = w_oor | (w_sel_we & w_misalign & (|w_sel_be));
`else
    assign w_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Storage: contents survive reset; error requests never write.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_xfer && w_sel_we && !w_err) begin
            for (int b = 0; b < c_BE_W; b++) begin
                if (w_sel_be[b]) begin
                    r_mem[w_word_idx][b*8 +: 8] <= w_sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return pipeline. Stage 0 loads at the acceptance edge, so the
    // last stage is visible exactly RD_LAT edges later. Data only advances
    // behind a read strobe, which makes the last stage hold its value.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] r_vld [RD_LAT];
    logic [NUM_CH-1:0] r_err [RD_LAT];
    logic [DATA_W-1:0] r_dat [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_vld[k] <= '0;
                r_err[k] <= '0;
                r_dat[k] <= '0;
            end
        end else begin
            r_vld[0] <= (w_xfer && !w_sel_we) ? w_grant : '0;
            r_err[0] <= (w_xfer && w_err) ? w_grant : '0;
            if (w_xfer && !w_sel_we) begin
                r_dat[0] <= w_err ? '0 : r_mem[w_word_idx];
            end
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_err[k] <= r_err[k-1];
                if (|r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    assign rdata_valid_out = r_vld[RD_LAT-1];
    assign rdata_out       = r_dat[RD_LAT-1];
    assign err_out         = r_err[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_arb_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_arb_ram                                                      |
// | Purpose  : Self-checking bench for arb_ram at RD_LAT=1 and RD_LAT=3 driven |
// |            by shared stimulus; scoreboard of expected read returns.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_arb_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  vin = '0;
    logic [1:0]  wen = '0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  be = '0;

    logic [1:0]  rdy1, rdy3, rv1, rv3, er1, er3;
    logic [31:0] rd1, rd3;

    arb_ram #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .NUM_CH(2), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .valid_in(vin), .ready_out(rdy1), .write_en_in(wen),
        .addr_in(addr), .write_data_in(wdata), .byte_en_in(be),
        .rdata_valid_out(rv1), .rdata_out(rd1), .err_out(er1));

    arb_ram #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .NUM_CH(2), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .valid_in(vin), .ready_out(rdy3), .write_en_in(wen),
        .addr_in(addr), .write_data_in(wdata), .byte_en_in(be),
        .rdata_valid_out(rv3), .rdata_out(rd3), .err_out(er3));

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          ch;
        logic [31:0] data;
        bit          rd;
        bit          err;
    } exp_t;

    exp_t        q [2][$];
    logic [31:0] last [2];
    logic [31:0] mem_m [1024];
    int          mptr = 0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          ngrant [2] = '{0, 0};
    bit          chk_en = 1'b0;
    logic [1:0]  acc = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard and reference model, evaluated half a cycle before each edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [1:0]  ev, ee, mg, ov, oe;
        logic [31:0] ed, od, a, wd;
        logic [3:0]  b4;
        string       sfx;
        int          g, i;
        bit          we, err;

        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                ev = '0;
                ee = '0;
                ed = last[d];
                if (q[d].size() > 0 && q[d][0].due == cyc) begin
                    e = q[d].pop_front();
                    if (e.rd) begin
                        ev[e.ch] = 1'b1;
                        ed = e.data;
                    end
                    if (e.err) ee[e.ch] = 1'b1;
                end
                sfx = (d == 0) ? "_lat1" : "_lat3";
                ov  = (d == 0) ? rv1 : rv3;
                od  = (d == 0) ? rd1 : rd3;
                oe  = (d == 0) ? er1 : er3;
                check({"rvalid", sfx}, ov, ev);
                check({"rdata", sfx}, od, ed);
                check({"err", sfx}, oe, ee);
                last[d] = ed;
            end
        end

        if (rdy1[0]) ngrant[0]++;
        if (rdy1[1]) ngrant[1]++;

        mg = '0;
        g  = -1;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                i = (mptr + k) % 2;
                if (g < 0 && vin[i]) g = i;
            end
        end
        if (g >= 0) mg[g] = 1'b1;
        check("ready_lat1", rdy1, mg);
        check("ready_lat3", rdy3, mg);
        acc = mg;

        if (rst) begin
            q[0].delete();
            q[1].delete();
            mptr    = 0;
            last[0] = '0;
            last[1] = '0;
            chk_en  = 1'b1;
        end else if (g >= 0) begin
            a   = addr[g*32 +: 32];
            wd  = wdata[g*32 +: 32];
            b4  = be[g*4 +: 4];
            we  = wen[g];
            err = 1'b0;
`ifdef ARB_RAM_ADDR_CHECK_EN
            err = (a[31:12] != 0) || (we && a[1:0] != 2'b00 && b4 != 4'h0);
`endif
            if (we && !err) begin
                for (int b = 0; b < 4; b++)
                    if (b4[b]) mem_m[a[11:2]][b*8 +: 8] = wd[b*8 +: 8];
            end
            if (!we || err) begin
                e.ch   = g;
                e.rd   = !we;
                e.err  = err;
                e.data = err ? 32'h0 : mem_m[a[11:2]];
                e.due  = cyc + 1;
                q[0].push_back(e);
                e.due  = cyc + 3;
                q[1].push_back(e);
            end
            mptr = (g + 1) % 2;
        end
    end

    // Present a request on one channel, hold it until accepted, then drop valid.
    task automatic req(input int ch, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
        logic [63:0] ok;
        vin[ch]             = 1'b1;
        wen[ch]             = we;
        addr[ch*32 +: 32]   = a;
        wdata[ch*32 +: 32]  = d;
        be[ch*4 +: 4]       = b;
        ok = '0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            @(posedge clk);
            ok = {63'd0, acc[ch]};
            #1;
        end
        check("accept", ok, 64'd1);
        vin[ch] = 1'b0;
    endtask

    initial begin
        int g0, g1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Full write then read back
        req(0, 1'b1, 32'h8, 32'hffff0000, 4'hf);
        req(0, 1'b0, 32'h8, 32'h0, 4'h0);
        repeat (4) @(posedge clk);
        #1;

        // Partial write via byte enables
        req(1, 1'b1, 32'h10, 32'h11223344, 4'hf);
        req(1, 1'b1, 32'h10, 32'haabbccdd, 4'b0101);
        req(1, 1'b0, 32'h10, 32'h0, 4'h0);

        // Preload and contention
        req(0, 1'b1, 32'h0, 32'hA, 4'hf);
        req(1, 1'b1, 32'h4, 32'hB, 4'hf);
        g0 = ngrant[0];
        g1 = ngrant[1];
        wen  = 2'b00;
        addr = {32'h4, 32'h0};
        vin  = 2'b11;
        repeat (8) @(posedge clk);
        #1 vin = 2'b00;
        check("fair_ch0", ngrant[0] - g0, 4);
        check("fair_ch1", ngrant[1] - g1, 4);
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back reads
        req(0, 1'b0, 32'h8, 32'h0, 4'h0);
        req(0, 1'b0, 32'h10, 32'h0, 4'h0);
        req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (5) @(posedge clk);
        #1;

        // Reset while a read is in flight; grant blocked during reset
        req(0, 1'b1, 32'h20, 32'hcafef00d, 4'hf);
        req(0, 1'b0, 32'h20, 32'h0, 4'h0);
        rst = 1'b1;
        wen[1] = 1'b0;
        addr[63:32] = 32'h4;
        vin[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wen[0] = 1'b0;
        addr[31:0] = 32'h20;
        vin[0] = 1'b1;
        @(negedge clk);
        check("ptr_after_rst_lat1", rdy1, 2'b01);
        check("ptr_after_rst_lat3", rdy3, 2'b01);
        @(posedge clk);
        #1 vin[0] = 1'b0;
        @(posedge clk);
        #1 vin[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Out-of-range, misaligned and wrapping accesses
        req(0, 1'b0, 32'h1000, 32'h0, 4'h0);
        req(1, 1'b1, 32'h22, 32'h12345678, 4'hf);
        req(1, 1'b0, 32'h20, 32'h0, 4'h0);
        req(0, 1'b1, 32'h1004, 32'h55, 4'hf);
        req(0, 1'b0, 32'h4, 32'h0, 4'h0);

        for (int i = 0; i < 20 && (q[0].size() + q[1].size()) > 0; i++) @(posedge clk);
        check("drain", q[0].size() + q[1].size(), 0);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
